// File: rtl/overcooked_pkg.sv
// Shared widths, constants and game-state encodings for the order/score datapath.
package overcooked_pkg;

    localparam int NUM_ORDERS = 4;
    localparam int ORDER_T_W  = 5;
    localparam logic [ORDER_T_W-1:0] ORDER_EMPTY = 5'h1F;
    localparam int POINT_W    = 10;
    localparam int POINT_MAX  = 1023;
    localparam int TIME_W     = 8;
    localparam int NET_W      = 12;

    typedef enum logic [2:0] {
        WELCOME = 3'd0,
        INTRO   = 3'd1,
        RUN     = 3'd2,
        PAUSE   = 3'd3,
        FINISH  = 3'd4
    } game_state_e;

    // Signed net score change folded back into the unsigned score range.
    function automatic logic [POINT_W-1:0] clamp_points(input logic signed [NET_W-1:0] net);
        if (net < 12'sd0) begin
            return {POINT_W{1'b0}};
        end else if (net > 12'sd1023) begin
            return POINT_W'(POINT_MAX);
        end else begin
            return net[POINT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second strobe: counts enabled cycles and pulses on the last cycle of each second.
module sec_tick_gen #(
    parameter int CYCLES_PER_SEC = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_SEC - 1);

    logic [CNT_W-1:0] count_r;

    assign tick = enable && (count_r == CNT_LAST);

    // Cycle counter; holds while disabled so a pause resumes mid-second.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            count_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/order_scheduler.sv
// Order slots, round timer and score for the running game state: spawns,
// ages and expires orders once per second and resolves serve pulses.
module order_scheduler
    import overcooked_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 100_000_000,
    parameter int ROUND_TIME     = 150,
    parameter int ORDER_TIME     = 30,
    parameter int SPAWN_PERIOD   = 20,
    parameter int SERVE_POINTS   = 20,
    parameter int EXPIRE_PENALTY = 10
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic                                  run,
    input  logic                                  serve,
    output logic [NUM_ORDERS-1:0]                 orders,
    output logic [NUM_ORDERS-1:0][ORDER_T_W-1:0]  order_times,
    output logic [POINT_W-1:0]                    point_total,
    output logic [TIME_W-1:0]                     time_left,
    output logic                                  serve_ack,
    output logic                                  serve_miss,
    output logic                                  game_over
);

    localparam int IDX_W   = $clog2(NUM_ORDERS);
    localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [SPAWN_W-1:0]   SPAWN_LAST = SPAWN_W'(SPAWN_PERIOD - 1);
    localparam logic [ORDER_T_W-1:0] ORDER_INIT = ORDER_T_W'(ORDER_TIME);
    localparam logic [TIME_W-1:0]    ROUND_INIT = TIME_W'(ROUND_TIME);

    logic [NUM_ORDERS-1:0]                orders_r, orders_n_s;
    logic [NUM_ORDERS-1:0][ORDER_T_W-1:0] order_times_r, times_n_s;
    logic [POINT_W-1:0]                   point_total_r;
    logic [TIME_W-1:0]                    time_left_r, time_left_n_s;
    logic                                 serve_ack_r, serve_miss_r, game_over_r, game_over_n_s;
    logic [SPAWN_W-1:0]                   spawn_cnt_r, spawn_n_s;

    logic                  enable_s, tick_s, serve_s, hit_s, spawn_due_s;
    logic                  tgt_found_s, free_found_s;
    logic [IDX_W-1:0]      tgt_idx_s, free_idx_s;
    logic [ORDER_T_W-1:0]  tgt_time_s;
    logic [NUM_ORDERS-1:0] take_s, served_s, live_s, expire_s, decr_s, spawn_s;
    logic [NET_W-1:0]      add_s, pen_s;
    logic signed [NET_W-1:0] net_s;

    assign enable_s = run && !game_over_r;
    assign serve_s  = serve && enable_s;
    assign hit_s    = serve_s && tgt_found_s;

    sec_tick_gen #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_sec_tick_gen (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enable(enable_s),
        .tick  (tick_s)
    );

    // Most urgent active slot (strict < keeps the lowest index on ties) and lowest free slot.
    always_comb begin
        tgt_found_s  = 1'b0;
        tgt_idx_s    = {IDX_W{1'b0}};
        tgt_time_s   = ORDER_EMPTY;
        free_found_s = 1'b0;
        free_idx_s   = {IDX_W{1'b0}};
        take_s       = {NUM_ORDERS{1'b0}};
        for (int i = 0; i < NUM_ORDERS; i++) begin
            take_s[i]    = orders_r[i] && (!tgt_found_s || (order_times_r[i] < tgt_time_s));
            tgt_idx_s    = take_s[i] ? IDX_W'(i) : tgt_idx_s;
            tgt_time_s   = take_s[i] ? order_times_r[i] : tgt_time_s;
            tgt_found_s  = tgt_found_s | take_s[i];
            free_idx_s   = (!orders_r[i] && !free_found_s) ? IDX_W'(i) : free_idx_s;
            free_found_s = free_found_s | !orders_r[i];
        end
    end

    assign spawn_due_s = tick_s && (spawn_cnt_r == SPAWN_LAST);

    // Per-slot next state; the served slot is neither aged nor expired, and only
    // slots free before this cycle can receive the spawn.
    always_comb begin
        pen_s      = {NET_W{1'b0}};
        orders_n_s = {NUM_ORDERS{1'b0}};
        times_n_s  = {NUM_ORDERS*ORDER_T_W{1'b1}};
        served_s   = {NUM_ORDERS{1'b0}};
        live_s     = {NUM_ORDERS{1'b0}};
        expire_s   = {NUM_ORDERS{1'b0}};
        decr_s     = {NUM_ORDERS{1'b0}};
        spawn_s    = {NUM_ORDERS{1'b0}};
        for (int i = 0; i < NUM_ORDERS; i++) begin
            served_s[i]   = hit_s && (tgt_idx_s == IDX_W'(i));
            live_s[i]     = orders_r[i] && !served_s[i];
            expire_s[i]   = tick_s && live_s[i] && (order_times_r[i] == {ORDER_T_W{1'b0}});
            decr_s[i]     = tick_s && live_s[i] && (order_times_r[i] != {ORDER_T_W{1'b0}});
            spawn_s[i]    = spawn_due_s && free_found_s && (free_idx_s == IDX_W'(i));
            orders_n_s[i] = spawn_s[i] | (live_s[i] & ~expire_s[i]);
            times_n_s[i]  = spawn_s[i]     ? ORDER_INIT :
                            !orders_n_s[i] ? ORDER_EMPTY :
                            decr_s[i]      ? order_times_r[i] - ORDER_T_W'(1) :
                                             order_times_r[i];
            pen_s         = pen_s + (expire_s[i] ? NET_W'(EXPIRE_PENALTY) : {NET_W{1'b0}});
        end
    end

    assign add_s = hit_s ? (NET_W'(SERVE_POINTS) + {{(NET_W-ORDER_T_W){1'b0}}, tgt_time_s})
                         : {NET_W{1'b0}};
    assign net_s = $signed({2'b00, point_total_r}) + $signed(add_s) - $signed(pen_s);

    assign spawn_n_s     = !tick_s     ? spawn_cnt_r :
                           spawn_due_s ? {SPAWN_W{1'b0}} : spawn_cnt_r + SPAWN_W'(1);
    assign time_left_n_s = (tick_s && (time_left_r != {TIME_W{1'b0}})) ? time_left_r - TIME_W'(1)
                                                                        : time_left_r;
    assign game_over_n_s = game_over_r | (tick_s && (time_left_r <= TIME_W'(1)));

    // State and output registers; game_over freezes everything through enable_s.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            orders_r      <= {NUM_ORDERS{1'b0}};
            order_times_r <= {NUM_ORDERS{ORDER_EMPTY}};
            point_total_r <= {POINT_W{1'b0}};
            time_left_r   <= ROUND_INIT;
            serve_ack_r   <= 1'b0;
            serve_miss_r  <= 1'b0;
            game_over_r   <= 1'b0;
            spawn_cnt_r   <= SPAWN_LAST;
        end else begin
            orders_r      <= orders_n_s;
            order_times_r <= times_n_s;
            point_total_r <= clamp_points(net_s);
            time_left_r   <= time_left_n_s;
            serve_ack_r   <= hit_s;
            serve_miss_r  <= serve_s && !tgt_found_s;
            game_over_r   <= game_over_n_s;
            spawn_cnt_r   <= spawn_n_s;
        end
    end

    assign orders      = orders_r;
    assign order_times = order_times_r;
    assign point_total = point_total_r;
    assign time_left   = time_left_r;
    assign serve_ack   = serve_ack_r;
    assign serve_miss  = serve_miss_r;
    assign game_over   = game_over_r;

endmodule
